// File: rtl/axi_wr_slv_mem.sv
// AXI3 write-path slave backed by a local word-addressed RAM.
// One outstanding burst; FIXED/INCR/WRAP; sticky SLVERR; backdoor read port.
module axi_wr_slv_mem #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ID_W-1:0]              awid,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ID_W-1:0]              wid,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_W-1:0]              bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
    output logic [DATA_W-1:0]            mem_rdata
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              burst_err;
    logic              err;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [ADDR_W-1:0] aw_step;
    logic              aw_len_ok;
    logic              aw_err;

    always_comb begin
        aw_step   = ADDR_W'(1) << awsize;
        aw_len_ok = (awlen == 8'd1) || (awlen == 8'd3) ||
                    (awlen == 8'd7) || (awlen == 8'd15);
        aw_err    = (awsize > 3'(LSB)) || (awburst == 2'd3) ||
                    ((awburst == 2'd2) &&
                     (!aw_len_ok || ((awaddr & (aw_step - ADDR_W'(1))) != '0)));
    end

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] widx;
    logic              hs;
    logic              last;
    logic              beat_err;
    logic              err_now;
    logic              we;

    always_comb begin
        step     = ADDR_W'(1) << size_q;
        mask     = step * (ADDR_W'(len_q) + ADDR_W'(1)) - ADDR_W'(1);
        widx     = addr_q >> LSB;
        hs       = (state == DATA) && wvalid && wready;
        last     = (cnt == len_q);
        beat_err = (wid != id_q) || (widx >= ADDR_W'(MEM_DEPTH));
        err_now  = err || beat_err || (wlast != last);
        we       = hs && !reset && !burst_err && !beat_err;
        unique case (burst_q)
            2'd1:    next_addr = addr_q + step;
            2'd2:    next_addr = (addr_q & ~mask) | ((addr_q + step) & mask);
            default: next_addr = addr_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= 2'b00;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt       <= '0;
            burst_err <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (awready && awvalid) begin
                        id_q      <= awid;
                        addr_q    <= awaddr;
                        len_q     <= awlen;
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        cnt       <= '0;
                        burst_err <= aw_err;
                        err       <= aw_err;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        state     <= DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                DATA: begin
                    if (hs) begin
                        cnt    <= cnt + 8'd1;
                        addr_q <= next_addr;
                        err    <= err_now;
                        // Burst ends on the beat count; wlast only feeds the error flag
                        if (last) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= err_now ? 2'b10 : 2'b00;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[widx[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_rdata <= '0;
        end else begin
            mem_rdata <= mem[mem_raddr];
        end
    end
endmodule

// File: tb/tb_axi_wr_slv_mem.sv
// Directed self-checking bench for axi_wr_slv_mem.
// Covers INCR/WRAP/FIXED, strobes, SLVERR cases, B backpressure and reset.
module tb_axi_wr_slv_mem;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [9:0]  mem_raddr = '0;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    axi_wr_slv_mem dut (
        .clock(clock), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size;
        awburst = burst; awvalid = 1'b1;
        while (!awready && n < 20) begin tick(); n++; end
        chk("aw_timeout", 32'(n < 20), 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [3:0] id, input logic [31:0] data,
                        input logic [3:0] strb, input logic last);
        int n = 0;
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 20) begin tick(); n++; end
        chk("w_timeout", 32'(n < 20), 32'd1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [3:0] eid,
                        input logic [1:0] eresp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk({tag, "_b_timeout"}, 32'(n < 20), 32'd1);
        chk({tag, "_bid"}, 32'(bid), 32'(eid));
        chk({tag, "_bresp"}, 32'(bresp), 32'(eresp));
        tick();
        bready = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [9:0] idx,
                      input logic [31:0] exp);
        mem_raddr = idx;
        tick();
        chk(tag, mem_rdata, exp);
    endtask

    task automatic single(input logic [31:0] addr, input logic [31:0] data);
        do_aw(4'd1, addr, 8'd0, 3'd2, 2'd1);
        do_w(4'd1, data, 4'hF, 1'b1);
        do_b("pre", 4'd1, 2'd0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bid", 32'(bid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_awready", 32'(awready), 32'd1);

        // Preloads for words that later tests expect unchanged
        single(32'h0000_0000, 32'h0000_600D);
        single(32'h0000_0020, 32'h0000_0000);
        single(32'h0000_002C, 32'h0000_2222);
        single(32'h0000_0040, 32'h0000_1616);

        // INCR
        do_aw(4'd3, 32'h10, 8'd3, 3'd2, 2'd1);
        chk("incr_awready_busy", 32'(awready), 32'd0);
        for (int i = 0; i < 4; i++)
            do_w(4'd3, 32'hA000_0000 + 32'(i), 4'hF, i == 3);
        do_b("incr", 4'd3, 2'd0);
        for (int i = 0; i < 4; i++)
            rd("incr_word", 10'(4 + i), 32'hA000_0000 + 32'(i));

        // WRAP from 0x18: words 6,7,4,5
        do_aw(4'd5, 32'h18, 8'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++)
            do_w(4'd5, 32'hD000_0000 + 32'(i), 4'hF, i == 3);
        do_b("wrap", 4'd5, 2'd0);
        rd("wrap_w6", 10'd6, 32'hD000_0000);
        rd("wrap_w7", 10'd7, 32'hD000_0001);
        rd("wrap_w4", 10'd4, 32'hD000_0002);
        rd("wrap_w5", 10'd5, 32'hD000_0003);

        // FIXED with byte strobes into word 8
        do_aw(4'd6, 32'h20, 8'd2, 3'd2, 2'd0);
        do_w(4'd6, 32'h0000_0011, 4'h1, 1'b0);
        do_w(4'd6, 32'h0000_2200, 4'h2, 1'b0);
        do_w(4'd6, 32'h0033_0000, 4'h4, 1'b1);
        do_b("fixed", 4'd6, 2'd0);
        rd("fixed_w8", 10'd8, 32'h0033_2211);

        // wid mismatch on beat 1
        do_aw(4'd2, 32'h28, 8'd1, 3'd2, 2'd1);
        do_w(4'd2, 32'h0000_00B0, 4'hF, 1'b0);
        do_w(4'd7, 32'h0000_00B1, 4'hF, 1'b1);
        do_b("widerr", 4'd2, 2'd2);
        rd("widerr_w10", 10'd10, 32'h0000_00B0);
        rd("widerr_w11", 10'd11, 32'h0000_2222);

        // Early wlast: both beats land, SLVERR
        do_aw(4'd8, 32'h48, 8'd1, 3'd2, 2'd1);
        do_w(4'd8, 32'h0000_0E00, 4'hF, 1'b1);
        do_w(4'd8, 32'h0000_0E01, 4'hF, 1'b1);
        do_b("wlast", 4'd8, 2'd2);
        rd("wlast_w18", 10'd18, 32'h0000_0E00);
        rd("wlast_w19", 10'd19, 32'h0000_0E01);

        // B backpressure
        do_aw(4'd9, 32'h30, 8'd0, 3'd2, 2'd1);
        do_w(4'd9, 32'h0000_CAFE, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", 32'(bvalid), 32'd1);
            chk("bp_bid", 32'(bid), 32'd9);
            chk("bp_bresp", 32'(bresp), 32'd0);
            chk("bp_awready", 32'(awready), 32'd0);
            tick();
        end
        do_b("bp", 4'd9, 2'd0);
        chk("bp_awready_after", 32'(awready), 32'd1);
        rd("bp_w12", 10'd12, 32'h0000_CAFE);

        // Reset mid-DATA
        do_aw(4'd4, 32'h38, 8'd3, 3'd2, 2'd1);
        do_w(4'd4, 32'h0000_00C0, 4'hF, 1'b0);
        reset = 1'b1;
        tick();
        chk("mrst_awready", 32'(awready), 32'd0);
        chk("mrst_wready", 32'(wready), 32'd0);
        chk("mrst_bvalid", 32'(bvalid), 32'd0);
        chk("mrst_bid", 32'(bid), 32'd0);
        chk("mrst_bresp", 32'(bresp), 32'd0);
        chk("mrst_rdata", mem_rdata, 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("mrst_no_b", 32'(bvalid), 32'd0);
        chk("mrst_awready", 32'(awready), 32'd1);
        rd("mrst_w14", 10'd14, 32'h0000_00C0);

        // Out-of-range address
        do_aw(4'd10, 32'h0000_1000, 8'd0, 3'd2, 2'd1);
        do_w(4'd10, 32'h0000_0BAD, 4'hF, 1'b1);
        do_b("oor", 4'd10, 2'd2);
        rd("oor_w0", 10'd0, 32'h0000_600D);

        // Reserved burst type
        do_aw(4'd11, 32'h40, 8'd1, 3'd2, 2'd3);
        do_w(4'd11, 32'h0000_DEAD, 4'hF, 1'b0);
        do_w(4'd11, 32'h0000_BEEF, 4'hF, 1'b1);
        do_b("rsvd", 4'd11, 2'd2);
        rd("rsvd_w16", 10'd16, 32'h0000_1616);

        // Oversized beat
        do_aw(4'd12, 32'h20, 8'd0, 3'd3, 2'd1);
        do_w(4'd12, 32'h0000_5A5A, 4'hF, 1'b1);
        do_b("size", 4'd12, 2'd2);
        rd("size_w8", 10'd8, 32'h0033_2211);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
